vga_frame_driver: RTL and testbench



---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_delay_line.sv | 38 +++
 rtl/vga_frame_driver.sv | 101 ++++++++++
 tb/tb_vga_frame_driver.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, RGB332 pixel format,
// the sprite transparency key and the RGB332 -> 24-bit expansion helper.
package vga_pkg;

    // Default 640x480 timing, pixel clocks / lines
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIPE_LAT = 2;

    // Width of pixelX / pixelY
    localparam int COORD_W = 11;

    // 8-bit pixel as produced by the sprite ROMs and the layer mux
    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Transparency key used by the sprite blocks and the mux
    localparam logic [7:0] MASK_VALUE = 8'h62;

    // 24-bit DAC colour
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Raster decode carried down the delay line alongside the pixel
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } timing_t;

    // Bit replication so full-scale codes reach 8'hFF and zero stays zero
    function automatic rgb888_t expand_rgb332(input rgb332_t pix);
        rgb888_t wide;
        wide.r = {pix.r, pix.r, pix.r[2:1]};
        wide.g = {pix.g, pix.g, pix.g[2:1]};
        wide.b = {pix.b, pix.b, pix.b, pix.b};
        return wide;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear. DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-1:0] delayed
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign delayed = sample;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            // Advance one stage per clock; reset flushes the whole line
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    // NOTE: every stage is cleared, not just the first, so no stale
                    // sync or blank decode can leak out after reset is released.
                    for (int i = 0; i < DEPTH; i++) begin
                        stages[i] <= '0;
                    end
                end else begin
                    stages[0] <= sample;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign delayed = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_frame_driver.sv
// Raster timing generator and DAC output stage. Issues pixel coordinates to
// the sprite/mux path, then re-aligns the returned pixel with sync and blank.
module vga_frame_driver
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   PIPE_LAT = DEF_PIPE_LAT,
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         RGB_in,
    output logic [COORD_W-1:0] pixelX,
    output logic [COORD_W-1:0] pixelY,
    output logic               startOfFrame,
    output logic [7:0]         oVGA_R,
    output logic [7:0]         oVGA_G,
    output logic [7:0]         oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK_N
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VISIBLE  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VISIBLE  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    timing_t raw;
    timing_t aligned;
    rgb888_t colour;

    // Horizontal counter every clock; vertical counter on horizontal wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixelX <= '0;
            pixelY <= '0;
        end else if (pixelX == H_LAST) begin
            // NOTE: non-blocking updates so pixelY's wrap test sees the pre-edge
            // counter values, same as every other register in this block.
            pixelX <= '0;
            pixelY <= (pixelY == V_LAST) ? '0 : pixelY + 1'b1;
        end else begin
            pixelX <= pixelX + 1'b1;
        end
    end

    assign startOfFrame = (pixelX == '0) && (pixelY == '0) && !reset;

    // Raw decode at counter time; off-screen coordinates pass through untouched
    assign raw.active = (pixelX < H_VISIBLE) && (pixelY < V_VISIBLE);
    assign raw.hs     = (pixelX >= HS_START) && (pixelX < HS_END);
    assign raw.vs     = (pixelY >= VS_START) && (pixelY < VS_END);

    // Hold the decode back until the mux returns the pixel for this coordinate
    vga_delay_line #(
        .WIDTH ($bits(timing_t)),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .sample  (raw),
        .delayed (aligned)
    );

    assign colour = expand_rgb332(rgb332_t'(RGB_in));

    // DAC output register: colour gated by blank, sync at its configured polarity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_BLANK_N <= 1'b0;
            oVGA_HS      <= ~SYNC_ACT;
            oVGA_VS      <= ~SYNC_ACT;
        end else begin
            oVGA_R       <= aligned.active ? colour.r : 8'h00;
            oVGA_G       <= aligned.active ? colour.g : 8'h00;
            oVGA_B       <= aligned.active ? colour.b : 8'h00;
            oVGA_BLANK_N <= aligned.active;
            oVGA_HS      <= aligned.hs ? SYNC_ACT : ~SYNC_ACT;
            oVGA_VS      <= aligned.vs ? SYNC_ACT : ~SYNC_ACT;
        end
    end

endmodule

// File: tb/tb_vga_frame_driver.sv
// Bench for vga_frame_driver. Two instances share clock and reset: one with a
// 2-deep pipe and active-low sync, one with the pipe bypassed and active-high
// sync. Small timing parameters keep whole frames short.
module tb_vga_frame_driver;

    localparam int HA = 40, HF = 4, HS = 6, HB = 10;
    localparam int VA = 12, VF = 2, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int PL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rgb_in = 8'h00;

    logic [10:0] px, py;
    logic        sof, hs, vs, blank_n;
    logic [7:0]  r, g, b;

    logic [10:0] px_z, py_z;
    logic        sof_z, hs_z, vs_z, blank_n_z;
    logic [7:0]  r_z, g_z, b_z, rgb_z;

    logic [49:0] obs_main, obs_z;

    int vectors = 0;
    int miscompares = 0;
    int cnt = 0;

    always #5 clk = ~clk;

    // Model time base: clock edges since reset was released
    always @(posedge clk or posedge reset) begin
        if (reset) cnt <= 0;
        else       cnt <= cnt + 1;
    end

    // Mux stand-in for the bypass build: pixel derived combinationally from coordinates
    assign rgb_z = {px_z[2:0], py_z[2:0], px_z[4:3]};

    assign obs_main = {sof, px, py, r, g, b, hs, vs, blank_n};
    assign obs_z    = {sof_z, px_z, py_z, r_z, g_z, b_z, hs_z, vs_z, blank_n_z};

    vga_frame_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_LAT(PL), .SYNC_ACT(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .RGB_in(rgb_in),
        .pixelX(px), .pixelY(py), .startOfFrame(sof),
        .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
        .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK_N(blank_n)
    );

    vga_frame_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_LAT(0), .SYNC_ACT(1'b1)
    ) dut_z (
        .clk(clk), .reset(reset), .RGB_in(rgb_z),
        .pixelX(px_z), .pixelY(py_z), .startOfFrame(sof_z),
        .oVGA_R(r_z), .oVGA_G(g_z), .oVGA_B(b_z),
        .oVGA_HS(hs_z), .oVGA_VS(vs_z), .oVGA_BLANK_N(blank_n_z)
    );

    // RGB332 -> 24 bit by scaling: 3-bit code * 36 + code/2, 2-bit code * 85
    function automatic logic [23:0] expand_ref(input int p);
        int rr = (p / 32) % 8;
        int gg = (p / 4) % 8;
        int bb = p % 4;
        int r8 = rr * 36 + rr / 2;
        int g8 = gg * 36 + gg / 2;
        int b8 = bb * 85;
        return {8'(r8), 8'(g8), 8'(b8)};
    endfunction

    // Pixel the bypass-build mux stand-in returns for raster position m
    function automatic int pattern(input int m);
        int x = m % HT;
        int y = (m / HT) % VT;
        return ((x % 8) * 32) + ((y % 8) * 4) + ((x / 8) % 4);
    endfunction

    // Expected outputs c edges after release; pix is the pixel sampled at edge c
    function automatic logic [49:0] expect_out(input int c, input int pl,
                                               input logic sa, input int pix);
        int   x = c % HT;
        int   y = (c / HT) % VT;
        int   m = c - pl - 1;
        int   mx = (m < 0) ? 0 : m % HT;
        int   my = (m < 0) ? 0 : (m / HT) % VT;
        logic s = (x == 0) && (y == 0);
        logic act = (mx < HA) && (my < VA);
        logic h = (mx >= HA + HF) && (mx < HA + HF + HS);
        logic v = (my >= VA + VF) && (my < VA + VF + VS);
        if (m < 0) return {s, 11'(x), 11'(y), 24'h0, ~sa, ~sa, 1'b0};
        return {s, 11'(x), 11'(y), act ? expand_ref(pix) : 24'h0,
                h ? sa : ~sa, v ? sa : ~sa, act};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (obs_main !== {1'b0, 22'h0, 24'h0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state_main observed=%h expected=%h", obs_main,
                     {1'b0, 22'h0, 24'h0, 1'b1, 1'b1, 1'b0});
        end
        vectors++;
        if (obs_z !== {1'b0, 22'h0, 24'h0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state_bypass observed=%h expected=%h", obs_z,
                     {1'b0, 22'h0, 24'h0, 1'b0, 1'b0, 1'b0});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({sof, px, py} !== {1'b1, 22'h0}) begin
            miscompares++;
            $display("FAIL release_sof observed=%h expected=%h", {sof, px, py}, {1'b1, 22'h0});
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({sof, px, py} !== {1'b0, 11'd1, 11'd0}) begin
            miscompares++;
            $display("FAIL first_step observed=%h expected=%h", {sof, px, py}, {1'b0, 11'd1, 11'd0});
        end
    endtask

    task automatic test_colour_expansion();
        logic [7:0]  vals [3] = '{8'hFF, 8'h62, 8'h00};
        logic [23:0] exps [3] = '{24'hFFFFFF, 24'h6D00AA, 24'h000000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rgb_in = vals[i];
            repeat (3) @(negedge clk);
            #1;
            vectors++;
            if ({blank_n, r, g, b} !== {1'b1, exps[i]}) begin
                miscompares++;
                $display("FAIL colour_%h observed=%h expected=%h", vals[i],
                         {blank_n, r, g, b}, {1'b1, exps[i]});
            end
        end
    endtask

    task automatic test_raster();
        int blank_cnt = 0, hs_low = 0, vs_low = 0, sof_cnt = 0;
        int first_hs = -1, last_sof = -1, period = 0;
        logic [49:0] exp_v;
        do_reset();
        for (int i = 0; i < 2 * FRAME + PL + 1; i++) begin
            exp_v = expect_out(cnt, PL, 1'b0, rgb_in);
            vectors++;
            if (obs_main !== exp_v) begin
                miscompares++;
                $display("FAIL raster cnt=%0d observed=%h expected=%h", cnt, obs_main, exp_v);
            end
            if (cnt >= PL + 1) begin
                if (blank_n) blank_cnt++;
                if (!hs) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = cnt;
                end
                if (!vs) vs_low++;
            end
            if (sof) begin
                if (last_sof >= 0) period = cnt - last_sof;
                last_sof = cnt;
                sof_cnt++;
            end
            rgb_in = 8'($urandom);
            @(negedge clk);
            #1;
        end
        vectors++;
        if (period !== FRAME || sof_cnt !== 3) begin
            miscompares++;
            $display("FAIL sof_period observed=%0d/%0d expected=%0d/3", period, sof_cnt, FRAME);
        end
        vectors++;
        if (first_hs !== PL + 1 + HA + HF) begin
            miscompares++;
            $display("FAIL first_hs observed=%0d expected=%0d", first_hs, PL + 1 + HA + HF);
        end
        vectors++;
        if (hs_low !== 2 * HS * VT) begin
            miscompares++;
            $display("FAIL hs_low_clocks observed=%0d expected=%0d", hs_low, 2 * HS * VT);
        end
        vectors++;
        if (vs_low !== 2 * VS * HT) begin
            miscompares++;
            $display("FAIL vs_low_clocks observed=%0d expected=%0d", vs_low, 2 * VS * HT);
        end
        vectors++;
        if (blank_cnt !== 2 * HA * VA) begin
            miscompares++;
            $display("FAIL active_clocks observed=%0d expected=%0d", blank_cnt, 2 * HA * VA);
        end
    endtask

    task automatic test_blanking();
        int lit = 0, lit_blank = 0;
        do_reset();
        rgb_in = 8'hFF;
        for (int i = 0; i < FRAME + PL + 1; i++) begin
            if (cnt >= PL + 1 && {r, g, b} != 24'h0) begin
                lit++;
                if (!blank_n) lit_blank++;
            end
            @(negedge clk);
            #1;
        end
        vectors++;
        if (lit !== HA * VA) begin
            miscompares++;
            $display("FAIL lit_pixels observed=%0d expected=%0d", lit, HA * VA);
        end
        vectors++;
        if (lit_blank !== 0) begin
            miscompares++;
            $display("FAIL lit_while_blank observed=%0d expected=0", lit_blank);
        end
    endtask

    task automatic test_mid_frame_reset();
        int stop;
        logic [49:0] exp_v;
        do_reset();
        stop = $urandom_range(FRAME / 3, 2 * FRAME / 3);
        while (cnt < stop) begin
            rgb_in = 8'($urandom);
            @(negedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (obs_main !== {1'b0, 22'h0, 24'h0, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL midframe_reset_main observed=%h expected=%h", obs_main,
                     {1'b0, 22'h0, 24'h0, 1'b1, 1'b1, 1'b0});
        end
        vectors++;
        if (obs_z !== {1'b0, 22'h0, 24'h0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL midframe_reset_bypass observed=%h expected=%h", obs_z,
                     {1'b0, 22'h0, 24'h0, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < HT + PL + 4; i++) begin
            exp_v = expect_out(cnt, PL, 1'b0, rgb_in);
            vectors++;
            if (obs_main !== exp_v) begin
                miscompares++;
                $display("FAIL after_reset cnt=%0d observed=%h expected=%h", cnt, obs_main, exp_v);
            end
            rgb_in = 8'($urandom);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_pipe_lat0();
        logic [49:0] exp_v;
        do_reset();
        for (int i = 0; i < FRAME + 2; i++) begin
            exp_v = expect_out(cnt, 0, 1'b1, (cnt >= 1) ? pattern(cnt - 1) : 0);
            vectors++;
            if (obs_z !== exp_v) begin
                miscompares++;
                $display("FAIL bypass cnt=%0d observed=%h expected=%h", cnt, obs_z, exp_v);
            end
            if (cnt == 1) begin
                vectors++;
                if ({blank_n_z, blank_n} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL first_visible observed=%b expected=10", {blank_n_z, blank_n});
                end
            end
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_colour_expansion();
        test_raster();
        test_blanking();
        test_mid_frame_reset();
        test_pipe_lat0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
